// File: rtl/expr_arbiter_if.sv
// expr_arbiter_if: character, result and status bundle for expr_arbiter.
// master feeds characters and accepts results; slave is the arbiter.
interface expr_arbiter_if #(
  parameter int VAL_W = 16
);
  logic             req0_valid;
  logic [7:0]       req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [7:0]       req1_data;
  logic             req1_ready;
  logic             res_valid;
  logic             res_ready;
  logic             res_ok;
  logic [VAL_W-1:0] res_value;
  logic             res_id;
  logic             busy;

  modport master (
    output req0_valid,
    output req0_data,
    input  req0_ready,
    output req1_valid,
    output req1_data,
    input  req1_ready,
    input  res_valid,
    output res_ready,
    input  res_ok,
    input  res_value,
    input  res_id,
    input  busy
  );

  modport slave (
    input  req0_valid,
    input  req0_data,
    output req0_ready,
    input  req1_valid,
    input  req1_data,
    output req1_ready,
    output res_valid,
    input  res_ready,
    output res_ok,
    output res_value,
    output res_id,
    output busy
  );
endinterface

// File: rtl/expr_arbiter.sv
// expr_arbiter: two character streams share one +/* expression evaluator.
// Define EXPR_ARB_TIMEOUT_EN to abort a stalled grant after TIMEOUT idle cycles.
module expr_arbiter #(
  parameter int         VAL_W   = 16,
  parameter logic [7:0] TERM    = 8'h3D,
  parameter int         TIMEOUT = 16
) (
  input logic           clk,
  input logic           clr_n,
  expr_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NUM,
    S_OPR,
    S_ERR,
    S_RES
  } state_t;

  state_t           state;
  logic             gnt;
  logic             last_id;
  logic [VAL_W-1:0] sum;
  logic [VAL_W-1:0] term;
  logic             mul_pend;

  logic             rdy0;
  logic             rdy1;
  logic             rvalid;
  logic             rok;
  logic [VAL_W-1:0] rval;
  logic             rid;
  logic             busy_q;

  logic [7:0]       ch;
  logic             xfer;
  logic             active;
  logic             pick;
  logic             is_dig;
  logic             is_plus;
  logic             is_mul;
  logic             is_term;
  logic [VAL_W-1:0] dval;
  logic             tmo;
  logic             fin_ok;
  logic             fin_bad;

  assign ch   = gnt ? bus.req1_data : bus.req0_data;
  assign xfer = gnt ? (bus.req1_valid & rdy1)
                    : (bus.req0_valid & rdy0);

  assign active = (state == S_NUM) |
                  (state == S_OPR) |
                  (state == S_ERR);

  // Contention goes to whoever was not served last.
  assign pick = (bus.req0_valid & bus.req1_valid)
              ? ~last_id
              : bus.req1_valid;

  always_comb begin
    is_dig  = (ch >= 8'h30) && (ch <= 8'h39);
    is_plus = (ch == 8'h2B);
    is_mul  = (ch == 8'h2A);
    is_term = (ch == TERM);
  end

  assign dval = VAL_W'(ch[3:0]);

`ifdef EXPR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] idle_cnt;

  assign tmo = active & ~xfer &
               (idle_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      idle_cnt <= '0;
    end else if (!active || xfer || tmo) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end
`else
  logic unused_timeout;

  assign tmo            = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  assign fin_ok  = xfer & is_term & (state == S_OPR);
  assign fin_bad = tmo |
                   (xfer & is_term &
                    ((state == S_NUM) | (state == S_ERR)));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= S_IDLE;
      gnt      <= 1'b0;
      last_id  <= 1'b1;
      sum      <= '0;
      term     <= '0;
      mul_pend <= 1'b0;
      rdy0     <= 1'b0;
      rdy1     <= 1'b0;
      rvalid   <= 1'b0;
      rok      <= 1'b0;
      rval     <= '0;
      rid      <= 1'b0;
      busy_q   <= 1'b0;
    end else if (fin_ok || fin_bad) begin
      state  <= S_RES;
      rvalid <= 1'b1;
      rok    <= fin_ok;
      rval   <= fin_ok ? (sum + term) : '0;
      rid    <= gnt;
      rdy0   <= 1'b0;
      rdy1   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.req0_valid || bus.req1_valid) begin
            state    <= S_NUM;
            gnt      <= pick;
            rdy0     <= ~pick;
            rdy1     <= pick;
            busy_q   <= 1'b1;
            sum      <= '0;
            term     <= '0;
            mul_pend <= 1'b0;
          end
        end
        S_NUM: begin
          if (xfer) begin
            if (is_dig) begin
              term  <= mul_pend ? (term * dval) : dval;
              state <= S_OPR;
            end else begin
              state <= S_ERR;
            end
          end
        end
        S_OPR: begin
          if (xfer) begin
            unique case (1'b1)
              is_plus: begin
                sum      <= sum + term;
                mul_pend <= 1'b0;
                state    <= S_NUM;
              end
              is_mul: begin
                mul_pend <= 1'b1;
                state    <= S_NUM;
              end
              default: state <= S_ERR;
            endcase
          end
        end
        S_ERR: begin
        end
        S_RES: begin
          if (bus.res_ready) begin
            last_id <= rid;
            rvalid  <= 1'b0;
            busy_q  <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.res_valid  = rvalid;
  assign bus.res_ok     = rok;
  assign bus.res_value  = rval;
  assign bus.res_id     = rid;
  assign bus.busy       = busy_q;

endmodule

// File: doc/expr_arbiter.md
# expr_arbiter

Arbitrates two ASCII character streams onto one shared expression-evaluation engine. The engine checks and evaluates single-digit infix expressions made of `+` and `*`, with `*` binding tighter than `+`. Each requester holds a grant for a whole expression, from the first character through the terminator. The block returns one result record per expression and sits between the character sources and the result consumer, alongside the existing expression checker in the lab datapath.

## Interface
- `VAL_W`, 16: result width; all arithmetic wraps modulo 2^VAL_W.
- `TERM`, 8'h3D (`=`): terminator character.
- `TIMEOUT`, 16: idle-cycle limit. Used only when `EXPR_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `clr_n` in 1: reset, asynchronous and active-low.
- `req0_valid` in 1 / `req0_data` in 8 / `req0_ready` out 1: requester 0 character handshake.
- `req1_valid` in 1 / `req1_data` in 8 / `req1_ready` out 1: requester 1 character handshake.
- `res_valid` out 1 / `res_ready` in 1: result handshake.
- `res_ok` out 1: the expression was well-formed.
- `res_value` out VAL_W: evaluated value; 0 when `res_ok`=0.
- `res_id` out 1: requester that owned the expression.
- `busy` out 1: a grant is held or a result is pending.

## Operation
- Character classes:
  - DIG is 8'h30–8'h39.
  - OP is 8'h2B (`+`) or 8'h2A (`*`).
  - TERM is the terminator.
  - Anything else is BAD.
- States:
  - IDLE: no grant.
  - NUM: expect a digit.
  - OPR: expect an operator or the terminator.
  - ERR: discard characters until the terminator.
  - RES: result pending.
- Arbitration happens in IDLE:
  - If exactly one `reqX_valid` is high, grant that requester and go to NUM.
  - If both are high, grant the requester other than `last_id`.
  - `last_id` resets to 1, so requester 0 wins first.
- Ready rules:
  - `reqX_ready` = 1 only for the granted requester, and only in NUM, OPR or ERR.
  - Otherwise it is 0.
  - A character transfers when valid & ready.
- Datapath: registers `sum`, `term` and `mul_pend`, all cleared on grant.
- NUM state, on a transferred character:
  - DIG: `term` ← `mul_pend` ? `term`·d : d; go to OPR.
  - TERM: empty expression or trailing operator; go to RES with `res_ok`=0.
  - OP or BAD: go to ERR.
- OPR state, on a transferred character:
  - `+`: `sum` ← `sum`+`term`, `mul_pend` ← 0; go to NUM.
  - `*`: `mul_pend` ← 1; go to NUM.
  - TERM: `res_value` ← `sum`+`term`, `res_ok` ← 1; go to RES.
  - DIG or BAD: go to ERR.
- ERR state: TERM goes to RES with `res_ok`=0; any other character is discarded.
- RES state:
  - `res_valid`=1, and `res_ok`, `res_value`, `res_id` are stable.
  - On `res_ready`=1: `last_id` ← `res_id`; go to IDLE.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values:
  - All outputs are 0; state is IDLE; `last_id`=1.
  - `sum`, `term` and `mul_pend` are 0.
- Grant latency:
  - If valid is seen in IDLE at cycle N, the grant is registered and ready is high at N+1.
  - Arbitration costs one bubble per expression.
- Throughput: one character per cycle while granted.
- Result latency: a terminator transferred at cycle N gives `res_valid`=1 at N+1.
- Back-pressure: while in RES, both readies are 0, and the result is held for as long as `res_ready` is 0.
- Handoff:
  - A result accepted at cycle M puts the block in IDLE at M+1.
  - A grant for a waiting requester is registered at M+1, and ready is high at M+2.
- A requester dropping valid mid-expression does not release the grant.
- Reset mid-operation: `clr_n` low immediately returns state to IDLE with outputs at their reset values. Any partial expression and any pending result are dropped.
- Multiplication keeps the low VAL_W bits; sums wrap.

## Configuration
- `EXPR_ARB_TIMEOUT_EN` defined:
  - In NUM, OPR and ERR, a counter increments on every cycle with no transfer and clears on each transfer.
  - Reaching TIMEOUT forces RES with `res_ok`=0 and `res_value`=0, and releases the grant.
- Not defined:
  - No counter is built; the `TIMEOUT` parameter is unused.
  - A grant is held indefinitely until the terminator arrives.

## Test plan
- Req0 streams `3+4*2=` with `res_ready`=1 → `res_valid` one cycle after `=`, with `res_ok`=1, `res_value`=11, `res_id`=0.
- Req1 streams `9*9*9+1=` → `res_ok`=1, `res_value`=730. With VAL_W=8, `res_value`=218 (wrap).
- Malformed inputs → each gives `res_ok`=0, `res_value`=0, with the error reached at the first offending character:
  - `3+=`
  - `=`
  - `34=`
  - `3a+1=`
- Both requesters valid from reset, each sending `1+1=` → req0 served first, then req1. `req1_ready` stays 0 until req0's result is accepted.
- Hold `res_ready`=0 for 10 cycles after a result → `res_valid`, `res_value` and `res_id` stay stable, and both readies stay 0.
- Pulse `clr_n` low midway through `5*` → all outputs 0, state IDLE. A following `2=` is evaluated as a fresh expression: `res_value`=2.
- With `EXPR_ARB_TIMEOUT_EN` and TIMEOUT=16, stall req0 after `5+` → after 16 idle cycles, `res_valid`=1 with `res_ok`=0, and req1 is granted next.
